// File: rtl/xbar_rx_deframer_if.sv
// Packet stream from one port's receive deframer to the crossbar input logic.
// The master drives the FIFO head (data, destination, valid) and the slave answers with ready.
interface xbar_rx_deframer_if #(
    parameter int PACKET_WIDTH = 8,
    parameter int PORTS        = 4
);
    logic [2*PACKET_WIDTH-1:0]  out_data;
    logic [$clog2(PORTS)-1:0]   out_dest;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output out_data,
        output out_dest,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_dest,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/xbar_rx_deframer.sv
// Per-port serial receiver: deframes start/data/stop bytes, pairs them into {header,payload}, buffers them in a FIFO.
// Optional feature macro XBAR_RX_PARITY_EN: an even-parity bit follows the data bits.
module xbar_rx_deframer #(
    parameter int PACKET_WIDTH = 8,
    parameter int PORTS        = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_en,
    input  logic                          serial_in,
    output logic [PACKET_WIDTH-1:0]       decoded_out,
    output logic                          byte_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    xbar_rx_deframer_if.master            bus
);

    localparam int DEST_W = $clog2(PORTS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = $clog2(PACKET_WIDTH);
    localparam int PKT_W  = 2 * PACKET_WIDTH;
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(PACKET_WIDTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef XBAR_RX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    function automatic logic even_parity(input logic [PACKET_WIDTH-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd3
    } state_t;
`endif

    state_t                    state_r;
    state_t                    next_state_s;
    logic [BCNT_W-1:0]         bit_cnt_r;
    logic [PACKET_WIDTH-1:0]   shift_r;
    logic [PACKET_WIDTH-1:0]   header_r;
    logic                      pending_r;
    logic [PACKET_WIDTH-1:0]   decoded_r;
    logic                      byte_valid_r;
    logic                      frame_err_r;
    logic                      push_r;
    logic [PKT_W-1:0]          push_data_r;
    logic                      par_ok_s;
    logic                      stop_sample_s;
    logic                      frame_good_s;
    logic                      frame_bad_s;

    logic [PKT_W-1:0]          mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic [PKT_W-1:0]          out_data_r;
    logic                      out_valid_r;
    logic                      overflow_r;
    logic                      pop_s;
    logic                      full_s;
    logic                      push_ok_s;
    logic                      drop_s;
    logic [CNT_W-1:0]          count_next_s;
    logic [PTR_W-1:0]          rd_next_s;
    logic                      head_valid_s;

`ifdef XBAR_RX_PARITY_EN
    logic par_ok_r;
    assign par_ok_s = par_ok_r;
`else
    assign par_ok_s = 1'b1;
`endif

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; the line only advances on bit-sample strobes.
    always_comb begin
        next_state_s = state_r;
        if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (!serial_in) next_state_s = ST_DATA;
                    else            next_state_s = ST_IDLE;
                end
                ST_DATA: begin
                    if (bit_cnt_r == BIT_LAST) begin
`ifdef XBAR_RX_PARITY_EN
                        next_state_s = ST_PAR;
`else
                        next_state_s = ST_STOP;
`endif
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end
`ifdef XBAR_RX_PARITY_EN
                ST_PAR:  next_state_s = ST_STOP;
`endif
                ST_STOP: next_state_s = ST_IDLE;
                default: next_state_s = ST_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Stop-bit verdict for the byte currently in the shift register.
    always_comb begin
        stop_sample_s = bit_en && (state_r == ST_STOP);
        frame_good_s  = 1'b0;
        frame_bad_s   = 1'b0;
        if (stop_sample_s) begin
            frame_good_s = serial_in && par_ok_s;
            frame_bad_s  = !(serial_in && par_ok_s);
        end else begin
            frame_good_s = 1'b0;
            frame_bad_s  = 1'b0;
        end
    end

    // Bit shifting, byte capture and header/payload pairing.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            header_r     <= '0;
            pending_r    <= 1'b0;
            decoded_r    <= '0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            push_r       <= 1'b0;
            push_data_r  <= '0;
`ifdef XBAR_RX_PARITY_EN
            par_ok_r     <= 1'b0;
`endif
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            push_r       <= 1'b0;
            if (bit_en && (state_r == ST_IDLE)) begin
                bit_cnt_r <= '0;
            end
            if (bit_en && (state_r == ST_DATA)) begin
                shift_r   <= {serial_in, shift_r[PACKET_WIDTH-1:1]};
                bit_cnt_r <= bit_cnt_r + BCNT_W'(1);
            end
`ifdef XBAR_RX_PARITY_EN
            if (bit_en && (state_r == ST_PAR)) begin
                par_ok_r <= (serial_in == even_parity(shift_r));
            end
`endif
            if (frame_good_s) begin
                decoded_r    <= shift_r;
                byte_valid_r <= 1'b1;
                if (pending_r) begin
                    push_r      <= 1'b1;
                    push_data_r <= {header_r, shift_r};
                    pending_r   <= 1'b0;
                end else begin
                    header_r  <= shift_r;
                    pending_r <= 1'b1;
                end
            end else if (frame_bad_s) begin
                frame_err_r <= 1'b1;
                pending_r   <= 1'b0;
            end
        end
    end

    // FIFO control; the head register is loaded from contents excluding this cycle's push.
    always_comb begin
        pop_s        = out_valid_r && bus.out_ready;
        full_s       = (count_r == FULL_CNT);
        push_ok_s    = push_r && (!full_s || pop_s);
        drop_s       = push_r && full_s && !pop_s;
        rd_next_s    = rd_ptr_r + PTR_W'(pop_s);
        head_valid_s = ((count_r - CNT_W'(pop_s)) != '0);
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Packet storage.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end
    end

    // FIFO pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r    <= rd_next_s;
            count_r     <= count_next_s;
            overflow_r  <= drop_s;
            out_valid_r <= head_valid_s;
            if (head_valid_s) begin
                out_data_r <= mem_r[rd_next_s];
            end else begin
                out_data_r <= '0;
            end
        end
    end

    assign decoded_out   = decoded_r;
    assign byte_valid    = byte_valid_r;
    assign frame_err     = frame_err_r;
    assign overflow      = overflow_r;
    assign fifo_count    = count_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_dest  = out_data_r[PACKET_WIDTH +: DEST_W];
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_xbar_rx_deframer.sv
// Scoreboard bench for xbar_rx_deframer: byte-level reference model feeds expected queues, a monitor checks outputs.
// Build with XBAR_RX_PARITY_EN defined to exercise the parity variant.
module tb_xbar_rx_deframer;
    localparam int PW    = 8;
    localparam int PORTS = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] decoded_out;
    logic       byte_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    xbar_rx_deframer_if #(.PACKET_WIDTH(PW), .PORTS(PORTS)) bus ();

    xbar_rx_deframer #(.PACKET_WIDTH(PW), .PORTS(PORTS), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_en      (bit_en),
        .serial_in   (serial_in),
        .decoded_out (decoded_out),
        .byte_valid  (byte_valid),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_pkts[$];
    logic [7:0]  exp_bytes[$];
    int          exp_ferr = 0;
    int          exp_ovf = 0;
    int          ferr_seen = 0;
    int          ovf_seen = 0;
    bit          pend = 1'b0;
    logic [7:0]  hdr = 8'h00;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    // One serial bit time: four clocks, strobe on the last.
    task automatic bit_time(input logic b);
        serial_in = b;
        cycle();
        cycle();
        cycle();
        bit_en = 1'b1;
        cycle();
        bit_en = 1'b0;
    endtask

    // Reference model for one received byte: pairing, frame errors, overflow.
    task automatic model_byte(input logic [7:0] d, input bit good, input bit pop_now);
        if (good) begin
            exp_bytes.push_back(d);
            if (pend) begin
                if (exp_pkts.size() < DEPTH || pop_now) exp_pkts.push_back({hdr, d});
                else exp_ovf++;
                pend = 1'b0;
            end else begin
                hdr  = d;
                pend = 1'b1;
            end
        end else begin
            exp_ferr++;
            pend = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input bit pop_now);
        bit good;
        bit_time(1'b0);
        for (int i = 0; i < PW; i++) bit_time(d[i]);
`ifdef XBAR_RX_PARITY_EN
        bit_time(par_b);
        good = stop_b && (par_b == ^d);
`else
        good = stop_b;
        if (par_b === 1'bx) good = 1'b0;
`endif
        bit_time(stop_b);
        model_byte(d, good, pop_now);
        serial_in = 1'b1;
        if (pop_now) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, 1'b1, ^d, 1'b0);
    endtask

    task automatic drain(input string name);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_pkts.size() != 0; i++) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_drained"}, exp_pkts.size(), 0);
        check({name, "_count0"}, fifo_count, 0);
        check({name, "_valid0"}, bus.out_valid, 0);
    endtask

    // Monitor: sampled just before each rising edge.
    initial begin : monitor
        logic        prev_hold;
        logic [15:0] prev_data;
        logic [15:0] e;
        logic [7:0]  eb;
        prev_hold = 1'b0;
        prev_data = 16'h0000;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, prev_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_pkts.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_pop actual=0x%0h expected=none", bus.out_data);
                    end else begin
                        e = exp_pkts.pop_front();
                        check("pkt_data", bus.out_data, e);
                        check("pkt_dest", bus.out_dest, e[PW +: 2]);
                    end
                end
                if (byte_valid) begin
                    if (exp_bytes.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_byte actual=0x%0h expected=none", decoded_out);
                    end else begin
                        eb = exp_bytes.pop_front();
                        check("decoded_out", decoded_out, eb);
                    end
                end
                if (frame_err) ferr_seen++;
                if (overflow) ovf_seen++;
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0] d;
        logic       stop_b;
        logic       par_b;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_decoded", decoded_out, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_dest", bus.out_dest, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic pair, no bypass latency, held head
        send_good(8'h02);
        send_good(8'hA5);
        @(negedge clk);
        @(negedge clk);
        check("t1_valid", bus.out_valid, 1);
        check("t1_data", bus.out_data, 16'h02A5);
        check("t1_dest", bus.out_dest, 2);
        check("t1_count", fifo_count, 1);
        repeat (6) @(negedge clk);
        drain("t1");

        // Five packets into a four-deep FIFO
        for (int k = 0; k < 5; k++) begin
            send_good(8'($urandom));
            send_good(8'($urandom));
        end
        repeat (4) @(negedge clk);
        check("t2_count_full", fifo_count, 4);
        check("t2_overflow", ovf_seen, exp_ovf);
        drain("t2");

        // Bad stop bit on payload discards the pending header
        send_good(8'h01);
        send_frame(8'h5A, 1'b0, ^8'h5A, 1'b0);
        send_good(8'h03);
        send_good(8'h11);
        @(negedge clk);
        @(negedge clk);
        check("t3_frame_err", ferr_seen, exp_ferr);
        check("t3_data", bus.out_data, 16'h0311);
        drain("t3");

        // Push into a full FIFO with a pop in the same cycle
        for (int k = 0; k < 4; k++) begin
            send_good(8'($urandom));
            send_good(8'($urandom));
        end
        send_good(8'($urandom));
        d = 8'($urandom);
        send_frame(d, 1'b1, ^d, 1'b1);
        repeat (3) @(negedge clk);
        check("t4_overflow", ovf_seen, exp_ovf);
        check("t4_count", fifo_count, 4);
        check("t4_head", bus.out_data, exp_pkts[0]);
        drain("t4");

        // Reset in the middle of the payload byte
        send_good(8'h3C);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        bit_time(1'b1);
        rst = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend = 1'b0;
        exp_pkts.delete();
        exp_bytes.delete();
        check("t5_decoded", decoded_out, 0);
        check("t5_byte_valid", byte_valid, 0);
        check("t5_count", fifo_count, 0);
        check("t5_valid", bus.out_valid, 0);
        check("t5_data", bus.out_data, 0);
        check("t5_frame_err", frame_err, 0);
        check("t5_overflow", overflow, 0);
        send_good(8'h00);
        send_good(8'hFF);
        @(negedge clk);
        @(negedge clk);
        check("t5_pair", bus.out_data, 16'h00FF);
        drain("t5");

`ifdef XBAR_RX_PARITY_EN
        // Parity bit wrong, then right
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t6_frame_err", ferr_seen, exp_ferr);
        check("t6_decoded", decoded_out, 8'h07);
`endif

        // Randomised traffic with random consumer backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 9) != 0);
            par_b  = (^d) ^ ($urandom_range(0, 9) == 0);
            send_frame(d, stop_b, par_b, 1'b0);
        end
        rand_ready = 1'b0;
        drain("rand");
        check("final_frame_err", ferr_seen, exp_ferr);
        check("final_overflow", ovf_seen, exp_ovf);
        check("final_bytes", exp_bytes.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
